// File: rtl/pipe_ctrl.sv
// pipe_ctrl: fetch PC, IF/ID register, forwarding scoreboard and load-use interlock.
// Ports:
//   clk, rst (async active-low)
//   imem_instruction in -> imem_address out (PC), id_instruction/id_valid out (IF/ID)
//   dec_* in: ID-stage sources, destination and load flag
//   br_taken/br_target in: ID-stage branch redirect
//   ext_busy in: freezes the whole pipeline
//   fwd_sel_a/b out: 0 = register file, k = stage k result; stall out; stage_valid out
module pipe_ctrl #(
    parameter int INSTRUCTION_WIDTH   = 32,
    parameter int REG_ADDRESS_LENGTH  = 5,
    parameter int PC_WIDTH            = 32,
    parameter int BRANCH_TARGET_WIDTH = 16,
    parameter int PC_STEP             = 4,
    parameter int NUM_FWD_STAGES      = 2,
    parameter int LOAD_USE_STALL      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INSTRUCTION_WIDTH-1:0]   imem_instruction,
    input  logic [REG_ADDRESS_LENGTH-1:0]  dec_rs_a,
    input  logic [REG_ADDRESS_LENGTH-1:0]  dec_rs_b,
    input  logic                           dec_use_a,
    input  logic                           dec_use_b,
    input  logic [REG_ADDRESS_LENGTH-1:0]  dec_rd,
    input  logic                           dec_wr_en,
    input  logic                           dec_is_load,
    input  logic                           br_taken,
    input  logic [BRANCH_TARGET_WIDTH-1:0] br_target,
    input  logic                           ext_busy,
    output logic [PC_WIDTH-1:0]            imem_address,
    output logic [INSTRUCTION_WIDTH-1:0]   id_instruction,
    output logic                           id_valid,
    output logic [2:0]                     fwd_sel_a,
    output logic [2:0]                     fwd_sel_b,
    output logic                           stall,
    output logic [NUM_FWD_STAGES-1:0]      stage_valid
);
    localparam int N = NUM_FWD_STAGES;

    logic [PC_WIDTH-1:0]                   pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0]          ir_q, ir_d;
    logic                                  idv_q, idv_d;
    logic [N-1:0]                          sb_v_q, sb_v_d, sb_w_q, sb_w_d, sb_ld_q, sb_ld_d;
    logic [N-1:0][REG_ADDRESS_LENGTH-1:0]  sb_rd_q, sb_rd_d;
    logic [N-1:0]                          hit_a, hit_b;
    logic [2:0]                            sel_a, sel_b;
    logic                                  stall_int;

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int k = 0; k < N; k++) begin
            hit_a[k] = sb_v_q[k] & sb_w_q[k] & (sb_rd_q[k] == dec_rs_a) & dec_use_a & idv_q;
            hit_b[k] = sb_v_q[k] & sb_w_q[k] & (sb_rd_q[k] == dec_rs_b) & dec_use_b & idv_q;
        end
        // scan oldest to youngest so the youngest hit is the one left standing
        sel_a = '0;
        sel_b = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit_a[k]) sel_a = 3'(k + 1);
            if (hit_b[k]) sel_b = 3'(k + 1);
        end
        stall_int = (LOAD_USE_STALL != 0) && !ext_busy && sb_ld_q[0] && (hit_a[0] || hit_b[0]);
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        idv_d   = idv_q;
        sb_v_d  = sb_v_q;
        sb_w_d  = sb_w_q;
        sb_ld_d = sb_ld_q;
        sb_rd_d = sb_rd_q;
        if (!ext_busy) begin
            for (int k = 1; k < N; k++) begin
                sb_v_d[k]  = sb_v_q[k-1];
                sb_w_d[k]  = sb_w_q[k-1];
                sb_ld_d[k] = sb_ld_q[k-1];
                sb_rd_d[k] = sb_rd_q[k-1];
            end
            if (stall_int) begin
                // fetch side holds; a bubble goes down the pipe behind the load
                sb_v_d[0]  = 1'b0;
                sb_w_d[0]  = 1'b0;
                sb_ld_d[0] = 1'b0;
                sb_rd_d[0] = '0;
            end else begin
                sb_v_d[0]  = idv_q;
                sb_w_d[0]  = dec_wr_en;
                sb_ld_d[0] = dec_is_load;
                sb_rd_d[0] = dec_rd;
                pc_d       = br_taken ? PC_WIDTH'(br_target) : pc_q + PC_WIDTH'(PC_STEP);
                ir_d       = br_taken ? '0 : imem_instruction;
                idv_d      = !br_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            idv_q   <= 1'b0;
            sb_v_q  <= '0;
            sb_w_q  <= '0;
            sb_ld_q <= '0;
            sb_rd_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            idv_q   <= idv_d;
            sb_v_q  <= sb_v_d;
            sb_w_q  <= sb_w_d;
            sb_ld_q <= sb_ld_d;
            sb_rd_q <= sb_rd_d;
        end
    end

    // stall and forwarding selects are forced quiet while reset is held
    assign imem_address   = pc_q;
    assign id_instruction = ir_q;
    assign id_valid       = idv_q;
    assign stage_valid    = sb_v_q;
    assign fwd_sel_a      = rst ? sel_a : 3'd0;
    assign fwd_sel_b      = rst ? sel_b : 3'd0;
    assign stall          = rst & stall_int;
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter REG_ADDRESS_LENGTH, default 5, register address width.
REQ-003 SHALL have parameter PC_WIDTH, default 32, instruction address width.
REQ-004 SHALL have parameter BRANCH_TARGET_WIDTH, default 16, branch target width; must be <= PC_WIDTH.
REQ-005 SHALL have parameter PC_STEP, default 4, PC increment per fetch.
REQ-006 SHALL have parameter NUM_FWD_STAGES, default 2, forwarding window depth; legal range 1..4.
REQ-007 SHALL have parameter LOAD_USE_STALL, default 1; 1 enables load-use interlock, 0 disables it.
REQ-008 SHALL have ports, one per line, name direction width meaning:
 clk  in  1  single clock; all state changes on its rising edge.
 rst  in  1  asynchronous, active-low reset.
 imem_instruction  in  INSTRUCTION_WIDTH  fetched word at imem_address.
 dec_rs_a, dec_rs_b  in  REG_ADDRESS_LENGTH  ID-stage source registers.
 dec_use_a, dec_use_b  in  1  source register is actually read.
 dec_rd  in  REG_ADDRESS_LENGTH  ID-stage destination.
 dec_wr_en  in  1  ID instruction writes dec_rd.
 dec_is_load  in  1  ID instruction is a memory/NIC load.
 br_taken  in  1  ID-stage branch resolved taken.
 br_target  in  BRANCH_TARGET_WIDTH  branch target address.
 ext_busy  in  1  dmem/NIC not ready; freezes pipeline.
 imem_address  out  PC_WIDTH  current PC.
 id_instruction  out  INSTRUCTION_WIDTH  IF/ID register.
 id_valid  out  1  id_instruction is a real instruction.
 fwd_sel_a, fwd_sel_b  out  3  0 = register file, k = stage k result (1 = youngest).
 stall  out  1  load-use interlock active this cycle.
 stage_valid  out  NUM_FWD_STAGES  bit k-1 = stage k holds a valid instruction.

Function
REQ-009 Scoreboard SHALL hold NUM_FWD_STAGES entries {valid, wr_en, rd, is_load}; entry 1 = instruction one cycle past ID.
REQ-010 A hit on source X at stage k SHALL require entry k valid, wr_en=1, rd=dec_rs_X, dec_use_X=1 and id_valid=1; register 0 is an ordinary register.
REQ-011 fwd_sel_X SHALL be the smallest k that hits (youngest wins), else 0; purely combinational from current state and inputs.
REQ-012 stall SHALL be 1 when LOAD_USE_STALL=1, ext_busy=0 and either source hits entry 1 with is_load=1; otherwise 0.
REQ-013 Priority per cycle SHALL be ext_busy > stall > br_taken > normal advance.
REQ-014 ext_busy=1: PC, IF/ID, id_valid and scoreboard SHALL all hold; br_taken ignored.
REQ-015 stall=1: PC and IF/ID SHALL hold, entry 1 SHALL load a bubble (valid=0), older entries shift; br_taken ignored.
REQ-016 br_taken=1 (not busy, not stalled): PC <= br_target zero-extended to PC_WIDTH; IF/ID <= 0; id_valid <= 0; ID instruction enters scoreboard normally.
REQ-017 Normal advance: PC <= PC+PC_STEP modulo 2^PC_WIDTH; IF/ID <= imem_instruction; id_valid <= 1; entry 1 <= {id_valid, dec_wr_en, dec_rd, dec_is_load}; entry k <= entry k-1.
REQ-018 Entry NUM_FWD_STAGES SHALL be discarded on shift; no other storage.
REQ-019 stage_valid SHALL mirror the scoreboard valid bits registered, no extra latency.
REQ-020 Branch-to-fetch latency SHALL be one cycle: instruction at br_target appears on id_instruction two edges after br_taken is sampled.

Reset
REQ-021 rst=0 SHALL immediately, without a clock, set PC=0, id_instruction=0, id_valid=0, all scoreboard entries cleared (stage_valid=0).
REQ-022 Release SHALL be synchronous to the next rising clk; first fetch at address 0 is registered on the first edge with rst=1.
REQ-023 Reset asserted mid-stall or mid-busy SHALL override all state; stall and fwd_sel outputs SHALL be 0 while rst=0.

Verification
REQ-024 Reset then 4 free cycles -> imem_address 0,4,8,12,16; id_valid 0 then 1.
REQ-025 ID: wr_en rd=7 (non-load); next ID reads rs_a=7 -> fwd_sel_a=1; one bubble later -> fwd_sel_a=2; NUM_FWD_STAGES=2 third cycle -> 0.
REQ-026 Load rd=3 followed by rs_b=3 user -> stall=1 one cycle, PC and id_instruction held, stage_valid[0]=0 next, then fwd_sel_b=2, stall=0; LOAD_USE_STALL=0 -> no stall, fwd_sel_b=1.
REQ-027 br_taken=1, br_target=0x0040 at PC=0x10 -> next PC=0x40, id_valid=0; following cycle id_instruction=word@0x40.
REQ-028 ext_busy=1 for 3 cycles with br_taken=1 -> no state change; on release branch taken; rst pulse low mid-busy -> all outputs 0 asynchronously.
REQ-029 PC_WIDTH=8, PC=0xFC -> next 0x00 (wrap); rs_a=rs_b=rd hit stage 1 and 2 -> both selects = 1.
